// File: rtl/ac_thermtrip_pkg.sv
// Shared encodings for the thermal-trip latch slice: FSM states, source bit
// positions and counter widths.
package ac_thermtrip_pkg;

    localparam int STATE_W    = 3;
    localparam int TRIP_CNT_W = 8;
    localparam int SRC_W      = 4;

    // Bit positions within iThermSrc_n / oThermSrc
    localparam int SRC_CPU0 = 0;
    localparam int SRC_CPU1 = 1;
    localparam int SRC_MEM0 = 2;
    localparam int SRC_MEM1 = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMING  = 3'd1,
        ST_ARMED   = 3'd2,
        ST_TRIP    = 3'd3,
        ST_LATCHED = 3'd4
    } state_e;

endpackage

// File: rtl/ac_sync_filter.sv
// 2-FF synchronizer followed by a consecutive-low-sample filter. oFilt_n goes
// low in the same cycle the count is about to reach FILTER, so the consumer's
// registered transition lands on the very edge the count saturates.
// FILTER must be at least 1.
module ac_sync_filter #(
    parameter logic [3:0] FILTER = 4'd4
) (
    input  logic iClk_2M,
    input  logic iRst_n,
    input  logic iEn,
    input  logic iSig_n,
    output logic oFilt_n
);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Synchronizer idles high so reset never looks like a trip
    always_ff @(posedge iClk_2M or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= iSig_n;
            sync2_q <= sync1_q;
        end
    end

    // Next low-run count: held at zero when disabled, any high sample restarts it
    always_comb begin
        cnt_d = cnt_q;
        if (!iEn) begin
            cnt_d = '0;
        end else if (sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q < FILTER) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Low-run count register
    always_ff @(posedge iClk_2M or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oFilt_n = (cnt_d != FILTER);

endmodule

// File: rtl/genCntr.sv
// Generic up-counter with synchronous clear (clear wins over enable).
module genCntr #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iClr,
    input  logic             iEn,
    output logic [WIDTH-1:0] oCnt
);

    logic [WIDTH-1:0] cnt_q;

    // Count while enabled, return to zero on clear
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
        end else if (iClr) begin
            cnt_q <= '0;
        end else if (iEn) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: rtl/ac_thermtrip_latch.sv
// Qualifies the delayed thermtrip against the CPU power window, requests an
// immediate power-down on a qualified trip, and latches the event and its
// source for the BMC until cleared after power-off.
module ac_thermtrip_latch
    import ac_thermtrip_pkg::*;
#(
    parameter logic [15:0] ARM_DLY      = 16'd2000,
    parameter logic [3:0]  FILTER       = 4'd4,
    parameter logic [15:0] SHDN_TIMEOUT = 16'd20000
) (
    input  logic                  iClk_2M,
    input  logic                  iRst_n,
    input  logic                  iPwrGdCpu,
    input  logic                  iPltRst_n,
    input  logic                  iFM_THERMTRIP_DLY_N,
    input  logic [SRC_W-1:0]      iThermSrc_n,
    input  logic                  iPwrDownDone,
    input  logic                  iClrLatch,
    output logic                  oThermtripShdnReq,
    output logic                  oThermtripLatched_n,
    output logic [SRC_W-1:0]      oThermSrc,
    output logic [TRIP_CNT_W-1:0] oTripCnt,
    output logic                  oShdnTimeout,
    output logic [STATE_W-1:0]    oState
);

    state_e                state_q, state_d;
    logic                  shdnReq_q, shdnReq_d;
    logic                  latched_n_q, latched_n_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [TRIP_CNT_W-1:0] tripCnt_q, tripCnt_d;
    logic                  timeout_q, timeout_d;

    logic [SRC_W-1:0]      srcSync1_q, srcSync2_q;
    logic                  tripFilt_n;
    logic [15:0]           armCnt;
    logic [15:0]           toCnt;

    // Source lines are asynchronous and idle high (inactive)
    always_ff @(posedge iClk_2M or negedge iRst_n) begin
        if (!iRst_n) begin
            srcSync1_q <= '1;
            srcSync2_q <= '1;
        end else begin
            srcSync1_q <= iThermSrc_n;
            srcSync2_q <= srcSync1_q;
        end
    end

    ac_sync_filter #(
        .FILTER (FILTER)
    ) uTripFilt (
        .iClk_2M (iClk_2M),
        .iRst_n  (iRst_n),
        .iEn     (state_q == ST_ARMED),
        .iSig_n  (iFM_THERMTRIP_DLY_N),
        .oFilt_n (tripFilt_n)
    );

    // Arm counter runs only while arming; any other state holds it cleared
    genCntr #(
        .WIDTH (16)
    ) uArmCntr (
        .iClk   (iClk_2M),
        .iRst_n (iRst_n),
        .iClr   (state_q != ST_ARMING),
        .iEn    (state_q == ST_ARMING),
        .oCnt   (armCnt)
    );

    // Shutdown timeout counter runs in ST_TRIP and parks at SHDN_TIMEOUT
    genCntr #(
        .WIDTH (16)
    ) uToCntr (
        .iClk   (iClk_2M),
        .iRst_n (iRst_n),
        .iClr   (state_q != ST_TRIP),
        .iEn    ((state_q == ST_TRIP) && (toCnt != SHDN_TIMEOUT)),
        .oCnt   (toCnt)
    );

    // Next-state and registered-output decisions; a trip outranks power loss
    always_comb begin
        state_d     = state_q;
        shdnReq_d   = shdnReq_q;
        latched_n_d = latched_n_q;
        src_d       = src_q;
        tripCnt_d   = tripCnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (iPwrGdCpu && iPltRst_n) begin
                    state_d = ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (!(iPwrGdCpu && iPltRst_n)) begin
                    state_d = ST_IDLE;
                end else if (armCnt == ARM_DLY - 16'd1) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!tripFilt_n) begin
                    state_d     = ST_TRIP;
                    shdnReq_d   = 1'b1;
                    latched_n_d = 1'b0;
                    src_d       = ~srcSync2_q;
                    if (tripCnt_q != '1) begin
                        tripCnt_d = tripCnt_q + 1'b1;
                    end
                end else if (!iPwrGdCpu) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIP: begin
                if (iPwrDownDone) begin
                    state_d   = ST_LATCHED;
                    shdnReq_d = 1'b0;
                end else if (toCnt >= SHDN_TIMEOUT - 16'd1) begin
                    timeout_d = 1'b1;
                end
            end
            ST_LATCHED: begin
                if (iClrLatch && !iPwrGdCpu) begin
                    state_d     = ST_IDLE;
                    latched_n_d = 1'b1;
                    src_d       = '0;
                    timeout_d   = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shdnReq_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge iClk_2M or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= ST_IDLE;
            shdnReq_q   <= 1'b0;
            latched_n_q <= 1'b1;
            src_q       <= '0;
            tripCnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shdnReq_q   <= shdnReq_d;
            latched_n_q <= latched_n_d;
            src_q       <= src_d;
            tripCnt_q   <= tripCnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign oThermtripShdnReq   = shdnReq_q;
    assign oThermtripLatched_n = latched_n_q;
    assign oThermSrc           = src_q;
    assign oTripCnt            = tripCnt_q;
    assign oShdnTimeout        = timeout_q;
    assign oState              = state_q;

endmodule

// File: tb/tb_ac_thermtrip_latch.sv
// Directed bench for ac_thermtrip_latch: a vector table for arming, trip and
// handshake, then hand-written sequences for glitches, trip-vs-power-loss,
// timeout, mid-trip reset and trip-count saturation (on a short-arm instance).
module tb_ac_thermtrip_latch;
    import ac_thermtrip_pkg::*;

    localparam logic [15:0] FAST_ARM = 16'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwrGdCpu;
    logic       pltRst_n;
    logic       tripDly_n;
    logic [3:0] thermSrc_n;
    logic       pwrDownDone;
    logic       clrLatch;

    logic       req, latN, tmo;
    logic [3:0] src;
    logic [7:0] cnt;
    logic [2:0] st;

    logic       fReq, fLatN, fTmo;
    logic [3:0] fSrc;
    logic [7:0] fCnt;
    logic [2:0] fSt;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       pg, plt, tripN;
        logic [3:0] srcN;
        logic       done, clr;
        int         cycles;
        logic [2:0] expState;
        logic       expReq, expLatN;
        logic [3:0] expSrc;
        logic [7:0] expCnt;
        logic       expTo;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ac_thermtrip_latch dut (
        .iClk_2M             (clk),
        .iRst_n              (rst_n),
        .iPwrGdCpu           (pwrGdCpu),
        .iPltRst_n           (pltRst_n),
        .iFM_THERMTRIP_DLY_N (tripDly_n),
        .iThermSrc_n         (thermSrc_n),
        .iPwrDownDone        (pwrDownDone),
        .iClrLatch           (clrLatch),
        .oThermtripShdnReq   (req),
        .oThermtripLatched_n (latN),
        .oThermSrc           (src),
        .oTripCnt            (cnt),
        .oShdnTimeout        (tmo),
        .oState              (st)
    );

    ac_thermtrip_latch #(
        .ARM_DLY      (FAST_ARM),
        .SHDN_TIMEOUT (16'd50)
    ) dutFast (
        .iClk_2M             (clk),
        .iRst_n              (rst_n),
        .iPwrGdCpu           (pwrGdCpu),
        .iPltRst_n           (pltRst_n),
        .iFM_THERMTRIP_DLY_N (tripDly_n),
        .iThermSrc_n         (thermSrc_n),
        .iPwrDownDone        (pwrDownDone),
        .iClrLatch           (clrLatch),
        .oThermtripShdnReq   (fReq),
        .oThermtripLatched_n (fLatN),
        .oThermSrc           (fSrc),
        .oTripCnt            (fCnt),
        .oShdnTimeout        (fTmo),
        .oState              (fSt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] eSt, input logic eReq,
                               input logic eLatN, input logic [3:0] eSrc,
                               input logic [7:0] eCnt, input logic eTo);
        checkVal({tag, ".state"}, 32'(st), 32'(eSt));
        checkVal({tag, ".req"}, 32'(req), 32'(eReq));
        checkVal({tag, ".latched_n"}, 32'(latN), 32'(eLatN));
        checkVal({tag, ".src"}, 32'(src), 32'(eSrc));
        checkVal({tag, ".tripCnt"}, 32'(cnt), 32'(eCnt));
        checkVal({tag, ".timeout"}, 32'(tmo), 32'(eTo));
    endtask

    task automatic setInputs(input logic pg, input logic plt, input logic tn,
                             input logic [3:0] sn, input logic dn, input logic cl);
        pwrGdCpu    = pg;
        pltRst_n    = plt;
        tripDly_n   = tn;
        thermSrc_n  = sn;
        pwrDownDone = dn;
        clrLatch    = cl;
    endtask

    task automatic applyStimulus(input vec_t v);
        setInputs(v.pg, v.plt, v.tripN, v.srcN, v.done, v.clr);
        tick(v.cycles);
    endtask

    function automatic vec_t mkVec(logic pg, logic plt, logic tn, logic [3:0] sn,
                                   logic dn, logic cl, int cyc, logic [2:0] eSt,
                                   logic eReq, logic eLatN, logic [3:0] eSrc,
                                   logic [7:0] eCnt, logic eTo);
        vec_t v;
        v.pg = pg; v.plt = plt; v.tripN = tn; v.srcN = sn; v.done = dn; v.clr = cl;
        v.cycles = cyc; v.expState = eSt; v.expReq = eReq; v.expLatN = eLatN;
        v.expSrc = eSrc; v.expCnt = eCnt; v.expTo = eTo;
        return v;
    endfunction

    initial begin
        // Arming, abort on power loss, ignored pulse, full arm, qualified trip
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 3,    ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1498, ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 3,    ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 10,   ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1998, ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMED,   1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 5,    ST_ARMED,   1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMED,   1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 5,    ST_ARMED,   1'b0, 1'b1, 4'h0, 8'd0, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1,    ST_TRIP,    1'b1, 1'b0, 4'h1, 8'd1, 1'b0));
        // Power-down handshake and clear qualification
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 99,   ST_TRIP,    1'b1, 1'b0, 4'h1, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1,    ST_LATCHED, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1,    ST_LATCHED, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 2,    ST_LATCHED, 1'b0, 1'b0, 4'h1, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1,    ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 2,    ST_IDLE,    1'b0, 1'b1, 4'h0, 8'd1, 1'b0));
        // Re-arm for the hand-written sequences
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1,    ST_ARMING,  1'b0, 1'b1, 4'h0, 8'd1, 1'b0));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2000, ST_ARMED,   1'b0, 1'b1, 4'h0, 8'd1, 1'b0));

        rst_n = 1'b0;
        setInputs(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        tick(3);
        checkOutput("reset", ST_IDLE, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expReq,
                        vecs[i].expLatN, vecs[i].expSrc, vecs[i].expCnt, vecs[i].expTo);
        end

        // Three-sample glitches never reach the four-sample filter
        for (int g = 0; g < 10; g++) begin
            tripDly_n = 1'b0;
            tick(3);
            tripDly_n = 1'b1;
            tick(3);
            checkVal($sformatf("glitch%0d.req", g), 32'(req), 32'd0);
        end
        tick(5);
        checkOutput("glitchEnd", ST_ARMED, 1'b0, 1'b1, 4'h0, 8'd1, 1'b0);

        // Trip qualifying on the same edge power good drops: the trip wins
        tripDly_n  = 1'b0;
        thermSrc_n = 4'b0011;
        tick(5);
        checkOutput("tripVsPwr.pre", ST_ARMED, 1'b0, 1'b1, 4'h0, 8'd1, 1'b0);
        pwrGdCpu = 1'b0;
        tick(1);
        checkOutput("tripVsPwr", ST_TRIP, 1'b1, 1'b0, 4'hC, 8'd2, 1'b0);

        // Shutdown timeout: flag rises exactly SHDN_TIMEOUT cycles after entry
        tripDly_n  = 1'b1;
        thermSrc_n = 4'hF;
        tick(19999);
        checkOutput("timeout.pre", ST_TRIP, 1'b1, 1'b0, 4'hC, 8'd2, 1'b0);
        tick(1);
        checkOutput("timeout.hit", ST_TRIP, 1'b1, 1'b0, 4'hC, 8'd2, 1'b1);
        tick(50);
        checkOutput("timeout.hold", ST_TRIP, 1'b1, 1'b0, 4'hC, 8'd2, 1'b1);
        pwrDownDone = 1'b1;
        tick(1);
        checkOutput("timeout.done", ST_LATCHED, 1'b0, 1'b0, 4'hC, 8'd2, 1'b1);
        pwrDownDone = 1'b0;
        clrLatch    = 1'b1;
        tick(1);
        checkOutput("timeout.clr", ST_IDLE, 1'b0, 1'b1, 4'h0, 8'd2, 1'b0);
        clrLatch = 1'b0;

        // Asynchronous reset while a shutdown request is active
        pwrGdCpu = 1'b1;
        pltRst_n = 1'b1;
        tick(2001);
        checkVal("rearm.state", 32'(st), 32'(ST_ARMED));
        tripDly_n  = 1'b0;
        thermSrc_n = 4'b1101;
        tick(6);
        checkOutput("midTrip", ST_TRIP, 1'b1, 1'b0, 4'h2, 8'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst", ST_IDLE, 1'b0, 1'b1, 4'h0, 8'd0, 1'b0);
        tripDly_n  = 1'b1;
        thermSrc_n = 4'hF;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkVal("postRst.arming", 32'(st), 32'(ST_ARMING));
        tick(1999);
        checkVal("postRst.fullArm", 32'(st), 32'(ST_ARMING));
        tick(1);
        checkVal("postRst.armed", 32'(st), 32'(ST_ARMED));

        // Trip-count saturation on the short-arm instance
        rst_n = 1'b0;
        setInputs(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        checkVal("fast.resetCnt", 32'(fCnt), 32'd0);
        for (int i = 0; i < 256; i++) begin
            setInputs(1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
            tick(int'(FAST_ARM) + 2);
            setInputs(1'b1, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0);
            tick(6);
            setInputs(1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
            tick(1);
            setInputs(1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
            tick(1);
            clrLatch = 1'b0;
            tick(1);
            checkVal($sformatf("sat%0d.cnt", i), 32'(fCnt), (i < 255) ? 32'(i + 1) : 32'd255);
            checkVal($sformatf("sat%0d.state", i), 32'(fSt), 32'(ST_IDLE));
        end
        checkVal("sat.fastLatched_n", 32'(fLatN), 32'd1);
        checkVal("sat.mainCnt", 32'(cnt), 32'd0);
        checkVal("sat.mainState", 32'(st), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
